// File: rtl/turbo_frame_ctrl.sv
// Frame sequencer for a turbo encoder: loads bytes from a ready/valid stream, walks each
// byte bit-serially through the constituent encoders, then runs trellis termination.
module turbo_frame_ctrl #(
    parameter int unsigned FRAME_BYTES = 4,
    parameter int unsigned TAIL_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic [7:0] il_data,
    output logic       il_load,
    output logic       enc_en,
    output logic [2:0] bit_sel,
    output logic       tail_en,
    output logic [7:0] byte_cnt,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {StIdle, StLoad, StEncode, StTail, StDone} state_e;

    localparam logic [7:0] FrameBytes = 8'(FRAME_BYTES);
    localparam logic [3:0] TailLast   = 4'(TAIL_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] il_data_q, byte_cnt_q;
    logic       il_load_q;
    logic       handshake, frame_start;

    // abort suppresses both the capture and the count update of a same-cycle handshake
    assign handshake   = (state_q == StLoad) && s_valid && !abort;
    assign frame_start = (state_q == StIdle) && start && !abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (start) state_d = StLoad;
                StLoad:   if (s_valid) state_d = StEncode;
                StEncode: begin
                    if (cnt_q == 4'd7) begin
                        state_d = (byte_cnt_q == FrameBytes) ? StTail : StLoad;
                    end
                end
                StTail:   if (cnt_q == TailLast) state_d = StDone;
                StDone:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Shared cycle counter: bit index in ENCODE, termination step in TAIL
    always_comb begin
        cnt_d = '0;
        if (state_q == StEncode || state_q == StTail) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            il_data_q  <= '0;
            il_load_q  <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            il_load_q <= handshake;
            if (handshake) begin
                il_data_q <= s_data;
            end
            if (frame_start) begin
                byte_cnt_q <= '0;
            end else if (handshake) begin
                byte_cnt_q <= byte_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        s_ready = 1'b0;
        enc_en  = 1'b0;
        tail_en = 1'b0;
        done    = 1'b0;
        busy    = (state_q != StIdle);
        unique case (state_q)
            StLoad:   s_ready = 1'b1;
            StEncode: enc_en  = 1'b1;
            StTail:   tail_en = 1'b1;
            StDone:   done    = 1'b1;
            default:  ;
        endcase
    end

    assign bit_sel  = enc_en ? cnt_q[2:0] : 3'd0;
    assign il_data  = il_data_q;
    assign il_load  = il_load_q;
    assign byte_cnt = byte_cnt_q;

endmodule

// File: doc/turbo_frame_ctrl.md
TURBO_FRAME_CTRL -- requirements
Module: turbo_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 4, meaning bytes per frame (legal range 1..255).
REQ-002 SHALL have parameter TAIL_CYCLES, default 3, meaning termination cycles per frame (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  frame request, sampled in IDLE only.
REQ-006 abort  input  1  synchronous frame abort.
REQ-007 s_valid  input  1  input byte valid.
REQ-008 s_data  input  8  input byte.
REQ-009 s_ready  output  1  byte accepted when s_valid and s_ready are both 1.
REQ-010 il_data  output  8  registered byte presented to interleaver.
REQ-011 il_load  output  1  one-cycle strobe: il_data is newly valid.
REQ-012 enc_en  output  1  constituent encoders advance one bit.
REQ-013 bit_sel  output  3  bit index of il_data fed to encoders this cycle.
REQ-014 tail_en  output  1  encoders in trellis-termination mode.
REQ-015 byte_cnt  output  8  bytes accepted in current frame.
REQ-016 busy  output  1  frame in progress (state not IDLE).
REQ-017 done  output  1  one-cycle pulse: frame complete.

Function
REQ-018 SHALL implement states IDLE, LOAD, ENCODE, TAIL, DONE in one state register.
REQ-019 IDLE: start=1 and abort=0 -> LOAD next cycle, byte_cnt cleared to 0; otherwise stay.
REQ-020 LOAD: s_ready=1; on handshake -> ENCODE next cycle; without handshake, stay.
REQ-021 On handshake, il_data SHALL take s_data and il_load SHALL be 1 for exactly the following cycle.
REQ-022 On handshake, byte_cnt SHALL increment by 1 at the same edge.
REQ-023 ENCODE: exactly 8 cycles, enc_en=1, bit_sel counts 0,1,...,7 (bit 0 first).
REQ-024 After ENCODE bit_sel=7: byte_cnt==FRAME_BYTES -> TAIL, else -> LOAD.
REQ-025 TAIL: exactly TAIL_CYCLES cycles, tail_en=1, enc_en=0; then -> DONE.
REQ-026 DONE: done=1 for one cycle; -> IDLE next cycle.
REQ-027 s_ready, enc_en, tail_en, busy, done SHALL decode directly from the state register; s_ready=0 outside LOAD.
REQ-028 s_valid outside LOAD SHALL be ignored; no data captured, byte_cnt unchanged.
REQ-029 start outside IDLE SHALL be ignored; no frame queued.
REQ-030 abort=1 in any non-IDLE state -> IDLE next cycle; done not pulsed; il_load forced 0; byte_cnt held.
REQ-031 start=1 and abort=1 together in IDLE: abort wins, stay IDLE.
REQ-032 abort=1 in LOAD together with a handshake: abort wins, byte not captured, byte_cnt unchanged.
REQ-033 FRAME_BYTES=1: a single LOAD/ENCODE pass SHALL then go to TAIL.
REQ-034 bit_sel SHALL be 0 in every state other than ENCODE.
REQ-035 Minimum frame time with s_valid held 1: start at cycle 0 -> done at cycle 9*FRAME_BYTES+TAIL_CYCLES+1.

Reset
REQ-036 reset=0 SHALL asynchronously force IDLE, il_data=0, il_load=0, bit_sel=0, byte_cnt=0, s_ready=0, enc_en=0, tail_en=0, busy=0, done=0.
REQ-037 Reset mid-frame SHALL discard the frame; after release the block SHALL wait in IDLE for a new start.
REQ-038 Reset release SHALL take effect on the next rising clk edge with no spurious il_load or done.

Verification
REQ-039 Defaults, s_valid=1, s_data=8'hAA..8'hAD, start pulse at cycle 0 -> s_ready at cycles 1,10,19,28; il_load at 2,11,20,29; TAIL 37-39; done at 40; byte_cnt=4.
REQ-040 s_valid=0 for 5 cycles in first LOAD -> s_ready held 1, no il_load; frame completes 5 cycles later (done at 45).
REQ-041 abort at cycle 15 (ENCODE, byte 2) -> IDLE at 16, busy=0, no done; a new start restarts with byte_cnt=0.
REQ-042 reset=0 asserted at cycle 5 between edges -> all outputs at reset values immediately; start during reset ignored.
REQ-043 start=1 and abort=1 in IDLE -> stays IDLE; start during TAIL -> ignored, exactly one done.
REQ-044 FRAME_BYTES=1, TAIL_CYCLES=1, s_data=8'h5A -> il_data=8'h5A at cycle 2, bit_sel 0..7 over cycles 2-9, tail_en at 10, done at 11.
